// File: rtl/nabp_filter_mapper_pkg.sv
// nabp_filter_mapper shared types and defaults.
// Widths and line size mirror the global NABP configuration.
package nabp_filter_mapper_pkg;

  localparam int CFG_DATA_WIDTH = 16;
  localparam int CFG_ADDR_WIDTH = 16;
  localparam int CFG_IMAGE_SIZE = 256;
  localparam int CFG_NUM_TAPS   = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

  typedef logic [CFG_NUM_TAPS-1:0][CFG_DATA_WIDTH-1:0] tap_vec_t;

endpackage

// File: rtl/nabp_filter_mapper_if.sv
// Shifter / RAM / PE-array signal bundle of the filter mapper.
// slave is the mapper side, master the surrounding system.
interface nabp_filter_mapper_if #(
  parameter int DATA_WIDTH = nabp_filter_mapper_pkg::CFG_DATA_WIDTH,
  parameter int NUM_TAPS   = nabp_filter_mapper_pkg::CFG_NUM_TAPS,
  parameter int ADDR_WIDTH = nabp_filter_mapper_pkg::CFG_ADDR_WIDTH
);

  logic                           sh_kick;
  logic [ADDR_WIDTH-1:0]          sh_base;
  logic                           sh_shift_en;
  logic                           sh_done;
  logic                           sh_ack;
  logic                           fr_en;
  logic [ADDR_WIDTH-1:0]          fr_addr;
  logic [DATA_WIDTH-1:0]          fr_data;
  logic                           pe_stall;
  logic [NUM_TAPS*DATA_WIDTH-1:0] pe_taps;
  logic                           pe_step;

  modport master (
    output sh_kick, sh_base, sh_shift_en, sh_done,
    output fr_data, pe_stall,
    input  sh_ack, fr_en, fr_addr, pe_taps, pe_step
  );

  modport slave (
    input  sh_kick, sh_base, sh_shift_en, sh_done,
    input  fr_data, pe_stall,
    output sh_ack, fr_en, fr_addr, pe_taps, pe_step
  );

endinterface

// File: rtl/nabp_tap_shifter.sv
// Tap register feeding the PE array.
// Tap 0 holds the newest sample; clear wins over shift.
module nabp_tap_shifter #(
  parameter int DATA_WIDTH = nabp_filter_mapper_pkg::CFG_DATA_WIDTH,
  parameter int NUM_TAPS   = nabp_filter_mapper_pkg::CFG_NUM_TAPS
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                clear,
  input  logic                                shift,
  input  logic [DATA_WIDTH-1:0]               din,
  output logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] taps
);

  // shift toward higher taps, inserting din at tap 0
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      taps <= '0;
    end else if (clear) begin
      taps <= '0;
    end else if (shift) begin
      taps <= {taps[NUM_TAPS-2:0], din};
    end
  end

endmodule

// File: rtl/nabp_filter_mapper.sv
// Maps shifter steps to filtered-RAM reads and PE tap updates.
// Return-cycle samples park in a one-entry skid while the PEs stall.
module nabp_filter_mapper #(
  parameter int DATA_WIDTH = nabp_filter_mapper_pkg::CFG_DATA_WIDTH,
  parameter int NUM_TAPS   = nabp_filter_mapper_pkg::CFG_NUM_TAPS,
  parameter int IMAGE_SIZE = nabp_filter_mapper_pkg::CFG_IMAGE_SIZE,
  parameter int ADDR_WIDTH = nabp_filter_mapper_pkg::CFG_ADDR_WIDTH
) (
  input logic                 clk,
  input logic                 reset_n,
  nabp_filter_mapper_if.slave bus
);

  import nabp_filter_mapper_pkg::*;

  localparam int IW = $clog2(IMAGE_SIZE + 1);

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [IW-1:0]         idx_q;
  logic                  idx_lt;
  logic                  kick;
  logic                  acc;

  logic                  ret_v_q;
  logic                  ret_sh_q;
  logic                  ret_rd_q;
  logic [DATA_WIDTH-1:0] ret_sample;

  logic                  skid_v_q;
  logic                  skid_sh_q;
  logic [DATA_WIDTH-1:0] skid_d_q;

  logic                  app_v;
  logic                  app_sh;
  logic [DATA_WIDTH-1:0] app_sample;
  logic                  step_q;

  logic [NUM_TAPS-1:0][DATA_WIDTH-1:0] taps;

  assign idx_lt = idx_q < IW'(IMAGE_SIZE);

  // state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state, step acceptance and RAM request
  always_comb begin
    state_d     = state_q;
    kick        = 1'b0;
    acc         = 1'b0;
    bus.sh_ack  = 1'b0;
    bus.fr_en   = 1'b0;
    bus.fr_addr = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.sh_kick) begin
          kick    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        bus.sh_ack = !bus.pe_stall && !skid_v_q;
        acc        = bus.sh_ack;
        if (acc && bus.sh_shift_en && idx_lt) begin
          bus.fr_en   = 1'b1;
          bus.fr_addr = base_q + ADDR_WIDTH'(idx_q);
        end
        if (bus.sh_done) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!ret_v_q && !skid_v_q) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // line base and saturating sample index
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q <= '0;
      idx_q  <= '0;
    end else if (kick) begin
      base_q <= bus.sh_base;
      idx_q  <= '0;
    end else if (acc && bus.sh_shift_en && idx_lt) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign ret_sample = ret_rd_q ? bus.fr_data : '0;

  // a step returns either straight from the RAM or from the skid
  always_comb begin
    app_sh     = 1'b0;
    app_sample = '0;
    unique case (1'b1)
      ret_v_q: begin
        app_sh     = ret_sh_q;
        app_sample = ret_sample;
      end
      skid_v_q: begin
        app_sh     = skid_sh_q;
        app_sample = skid_d_q;
      end
      default: ;
    endcase
  end

  assign app_v = (ret_v_q || skid_v_q) && !bus.pe_stall;

  // return-cycle tracking, skid capture and step pulse
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ret_v_q   <= 1'b0;
      ret_sh_q  <= 1'b0;
      ret_rd_q  <= 1'b0;
      skid_v_q  <= 1'b0;
      skid_sh_q <= 1'b0;
      skid_d_q  <= '0;
      step_q    <= 1'b0;
    end else begin
      ret_v_q  <= acc;
      ret_sh_q <= acc && bus.sh_shift_en;
      ret_rd_q <= bus.fr_en;
      step_q   <= app_v;
      if (ret_v_q && bus.pe_stall) begin
        skid_v_q  <= 1'b1;
        skid_sh_q <= ret_sh_q;
        skid_d_q  <= ret_sample;
      end else if (skid_v_q && !bus.pe_stall) begin
        skid_v_q <= 1'b0;
      end
    end
  end

  nabp_tap_shifter #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_TAPS   (NUM_TAPS)
  ) u_taps (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (kick),
    .shift   (app_v && app_sh),
    .din     (app_sample),
    .taps    (taps)
  );

  assign bus.pe_taps = taps;
  assign bus.pe_step = step_q;

endmodule

// File: tb/tb_nabp_filter_mapper.sv
// Self-checking bench for nabp_filter_mapper.
// Directed table, line sequences and a randomized model run.
module tb_nabp_filter_mapper;

  import nabp_filter_mapper_pkg::*;

  localparam int DW = CFG_DATA_WIDTH;
  localparam int NT = CFG_NUM_TAPS;
  localparam int IS = CFG_IMAGE_SIZE;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  always #5 clk = ~clk;

  nabp_filter_mapper_if bus ();

  nabp_filter_mapper dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit scr     = 1'b0;

  function automatic void chk(input string name,
                              input logic [127:0] got,
                              input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h need %0h", name, got, exp);
    end
  endfunction

  function automatic logic [15:0] ram_val(input logic [15:0] a);
    return scr ? (a ^ 16'h3c5a) : a;
  endfunction

  function automatic logic [NT*DW-1:0] exp_window(input logic [15:0] base,
                                                  input int nsh);
    logic [NT*DW-1:0] v;
    v = '0;
    for (int k = 0; k < NT; k++) begin
      int j;
      j = nsh - 1 - k;
      if (j >= 0 && j < IS) v[k*DW +: DW] = ram_val(16'(base + j));
    end
    return v;
  endfunction

  always @(posedge clk)
    bus.fr_data <= bus.fr_en ? ram_val(bus.fr_addr) : 16'hdead;

  logic [15:0] rd_q[$];
  tap_vec_t    step_q[$];

  bit          mdl_en = 1'b0;
  logic [15:0] m_base;
  int          m_nsh;
  logic [15:0] m_hist[$];
  tap_vec_t    m_exp[$];

  function automatic tap_vec_t m_window();
    tap_vec_t v;
    v = '0;
    for (int k = 0; k < NT; k++)
      if (k < m_hist.size()) v[k] = m_hist[k];
    return v;
  endfunction

  task automatic model_cycle();
    logic [15:0] s;
    if (bus.pe_stall) chk("rnd_ack_stall", bus.sh_ack, 0);
    if (bus.sh_ack) begin
      if (bus.sh_shift_en) begin
        if (m_nsh < IS) begin
          chk("rnd_rd_en", bus.fr_en, 1);
          chk("rnd_rd_addr", bus.fr_addr, 16'(m_base + m_nsh));
          s = ram_val(16'(m_base + m_nsh));
        end else begin
          chk("rnd_pad_no_rd", bus.fr_en, 0);
          s = '0;
        end
        m_hist.push_front(s);
        m_nsh++;
      end else begin
        chk("rnd_hold_no_rd", bus.fr_en, 0);
      end
      m_exp.push_back(m_window());
    end else begin
      chk("rnd_idle_no_rd", bus.fr_en, 0);
    end
  endtask

  always @(negedge clk) begin
    if (bus.fr_en) rd_q.push_back(bus.fr_addr);
    if (bus.pe_step) step_q.push_back(bus.pe_taps);
    if (mdl_en) model_cycle();
  end

  task automatic cyc();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    rd_q.delete();
    step_q.delete();
  endtask

  task automatic idle_in();
    bus.sh_kick     = 1'b0;
    bus.sh_shift_en = 1'b0;
    bus.sh_done     = 1'b0;
    bus.pe_stall    = 1'b0;
  endtask

  task automatic run_line(input logic [15:0] base, input int n,
                          input bit alt, input int st0, input int stn);
    int k;
    int ci;
    idle_in();
    bus.sh_kick = 1'b1;
    bus.sh_base = base;
    cyc();
    bus.sh_kick = 1'b0;
    k = 0;
    ci = 1;
    while (k < n && ci < 2000) begin
      bus.sh_shift_en = alt ? (k % 2 == 0) : 1'b1;
      bus.pe_stall = (ci >= st0 && ci < st0 + stn);
      bus.sh_done = (k == n - 1);
      @(negedge clk);
      if (bus.pe_stall || (stn > 0 && ci == st0 + stn))
        chk($sformatf("stall_ack_c%0d", ci), bus.sh_ack, 0);
      if (bus.sh_ack) k++;
      @(posedge clk);
      #1;
      ci++;
    end
    if (k < n) chk("line_timeout", k, n);
    idle_in();
    repeat (4) cyc();
  endtask

  task automatic check_steps(input string name, input logic [15:0] base,
                             input int n, input bit alt);
    chk({name, "_steps"}, step_q.size(), n);
    for (int j = 0; j < step_q.size() && j < n; j++)
      chk($sformatf("%s_taps%0d", name, j), step_q[j],
          exp_window(base, alt ? j / 2 + 1 : j + 1));
  endtask

  typedef struct {
    logic        kick;
    logic [15:0] base;
    logic        sh;
    logic        dn;
    logic        ack;
    logic        en;
    logic [15:0] addr;
    logic        step;
    logic [15:0] t0;
    logic [15:0] t7;
  } vec_t;

  vec_t tv[16];

  initial begin
    for (int c = 0; c < 16; c++) begin
      tv[c] = '{1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0,
                16'h0, 1'b0, 16'h0, 16'h0};
      if (c >= 1 && c <= 8) begin
        tv[c].sh   = 1'b1;
        tv[c].dn   = (c == 8);
        tv[c].ack  = 1'b1;
        tv[c].en   = 1'b1;
        tv[c].addr = 16'(16'h100 + c - 1);
      end
      if (c >= 3 && c <= 10) begin
        tv[c].step = 1'b1;
        tv[c].t0   = 16'(16'h100 + c - 3);
      end
    end
    tv[0].kick  = 1'b1;
    tv[0].base  = 16'h100;
    tv[9].kick  = 1'b1;
    tv[9].base  = 16'h999;
    tv[10].t7   = 16'h100;
    tv[11].kick = 1'b1;
    tv[11].base = 16'h200;
    tv[11].t0   = 16'h107;
    tv[11].t7   = 16'h100;
    tv[12].sh   = 1'b1;
    tv[12].dn   = 1'b1;
    tv[12].ack  = 1'b1;
    tv[12].en   = 1'b1;
    tv[12].addr = 16'h200;
    tv[14].step = 1'b1;
    tv[14].t0   = 16'h200;
    tv[15].t0   = 16'h200;

    idle_in();
    bus.sh_base = 16'h1234;
    bus.sh_kick = 1'b1;
    reset_n = 1'b0;
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_ack", bus.sh_ack, 0);
    chk("rst_fr_en", bus.fr_en, 0);
    chk("rst_fr_addr", bus.fr_addr, 0);
    chk("rst_taps", bus.pe_taps, 0);
    chk("rst_step", bus.pe_step, 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    bus.sh_kick = 1'b0;
    bus.sh_shift_en = 1'b1;
    @(negedge clk);
    chk("post_rst_idle", bus.sh_ack, 0);
    @(posedge clk);
    #1;
    idle_in();
    clr();

    for (int c = 0; c < 16; c++) begin
      bus.sh_kick     = tv[c].kick;
      bus.sh_base     = tv[c].base;
      bus.sh_shift_en = tv[c].sh;
      bus.sh_done     = tv[c].dn;
      bus.pe_stall    = 1'b0;
      @(negedge clk);
      chk($sformatf("vec%0d_ack", c), bus.sh_ack, tv[c].ack);
      chk($sformatf("vec%0d_en", c), bus.fr_en, tv[c].en);
      if (tv[c].en)
        chk($sformatf("vec%0d_addr", c), bus.fr_addr, tv[c].addr);
      chk($sformatf("vec%0d_step", c), bus.pe_step, tv[c].step);
      chk($sformatf("vec%0d_tap0", c), bus.pe_taps[DW-1:0], tv[c].t0);
      chk($sformatf("vec%0d_tap7", c),
          bus.pe_taps[(NT-1)*DW +: DW], tv[c].t7);
      @(posedge clk);
      #1;
    end
    idle_in();
    repeat (2) cyc();

    clr();
    run_line(16'h0040, 6, 1'b1, 0, 0);
    chk("alt_reads", rd_q.size(), 3);
    if (rd_q.size() == 3) begin
      chk("alt_rd0", rd_q[0], 16'h40);
      chk("alt_rd2", rd_q[2], 16'h42);
    end
    check_steps("alt", 16'h0040, 6, 1'b1);

    clr();
    run_line(16'hfff0, 260, 1'b0, 0, 0);
    chk("sat_reads", rd_q.size(), IS);
    if (rd_q.size() == IS) begin
      chk("sat_rd_first", rd_q[0], 16'hfff0);
      chk("sat_rd_wrap", rd_q[16], 16'h0000);
      chk("sat_rd_last", rd_q[IS-1], 16'h00ef);
    end
    check_steps("sat", 16'hfff0, 260, 1'b0);

    clr();
    run_line(16'h0300, 8, 1'b0, 4, 5);
    chk("stall_reads", rd_q.size(), 8);
    check_steps("stall", 16'h0300, 8, 1'b0);
    if (step_q.size() == 8) begin
      chk("stall_final_tap0", step_q[7][0], 16'h307);
      chk("stall_final_tap7", step_q[7][NT-1], 16'h300);
    end

    clr();
    idle_in();
    bus.sh_kick = 1'b1;
    bus.sh_base = 16'h0500;
    cyc();
    bus.sh_kick = 1'b0;
    bus.sh_shift_en = 1'b1;
    repeat (3) cyc();
    reset_n = 1'b0;
    @(negedge clk);
    chk("mid_rd_inflight", bus.fr_en, 1);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("mid_rst_ack%0d", c), bus.sh_ack, 0);
      chk($sformatf("mid_rst_step%0d", c), bus.pe_step, 0);
      chk($sformatf("mid_rst_taps%0d", c), bus.pe_taps, 0);
      @(posedge clk);
      #1;
    end
    idle_in();
    cyc();

    scr = 1'b1;
    clr();
    m_base = 16'($urandom);
    m_nsh = 0;
    m_hist.delete();
    m_exp.delete();
    mdl_en = 1'b1;
    bus.sh_kick = 1'b1;
    bus.sh_base = m_base;
    cyc();
    for (int c = 0; c < 700; c++) begin
      bus.sh_kick     = ($urandom_range(0, 7) == 0);
      bus.sh_base     = 16'($urandom);
      bus.sh_shift_en = ($urandom_range(0, 3) != 0);
      bus.pe_stall    = ($urandom_range(0, 3) == 0);
      bus.sh_done     = (c == 699);
      if (c == 699) bus.pe_stall = 1'b0;
      cyc();
    end
    bus.sh_kick = 1'b0;
    bus.sh_done = 1'b0;
    for (int c = 0; c < 8; c++) begin
      bus.sh_shift_en = ($urandom_range(0, 1) == 0);
      bus.pe_stall    = ($urandom_range(0, 1) == 0);
      cyc();
    end
    idle_in();
    repeat (5) cyc();
    mdl_en = 1'b0;
    chk("rnd_steps", step_q.size(), m_exp.size());
    for (int j = 0; j < step_q.size() && j < m_exp.size(); j++)
      chk($sformatf("rnd_taps%0d", j), step_q[j], m_exp[j]);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
